// File: rtl/decoder_arb_pkg.sv
// decoder_arb_pkg: shared FSM state type, default widths and the response
// timeout limit used by decoder_arb and its round-robin picker.
package decoder_arb_pkg;

    localparam int CODE_W_DEF = 7;
    localparam int RES_W_DEF  = 16;

    // Number of consecutive un-accepted RESP cycles before a response is dropped
    // (only used when the timeout build option is enabled).
    localparam int TMO_LIMIT  = 255;
    localparam int TMO_W      = 8;

    // Width of the decoder-latency down-counter; DEC_LAT is at most 7.
    localparam int LAT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/decoder_rr_pick.sv
// decoder_rr_pick: combinational round-robin selector. The search starts one
// slot after the last granted index and wraps; the first active request wins.
// Outputs a one-hot grant (all zero when nothing is requesting) and its index.
module decoder_rr_pick
    import decoder_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    // Walk NREQ candidate slots in rotated order; lock onto the first active one.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_i[(int'(last_i) + k) % NREQ]) begin
                found                               = 1'b1;
                gnt_o[(int'(last_i) + k) % NREQ]    = 1'b1;
                idx_o                               = IDX_W'((int'(last_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/decoder_arb.sv
// decoder_arb: serialises NREQ requesters onto one shared decoder whose
// result is valid DEC_LAT cycles after dec_in changes. One transaction is in
// flight at a time; the response is held until the consumer accepts it.
// Build option: define DECODER_ARB_TIMEOUT_EN to drop responses that are not
// accepted within TMO_LIMIT RESP cycles and flag it on timeout_err.
//
// state | meaning
// IDLE  | no transaction; grants one active requester and latches its code
// DRIVE | dec_in freshly updated; loads the latency counter
// WAIT  | counts down decoder latency; captures dec_res when counter is 0
// RESP  | rsp_valid held with stable id/data until rsp_ready (or timeout)
module decoder_arb
    import decoder_arb_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  CODE_W  = CODE_W_DEF,
    parameter int  RES_W   = RES_W_DEF,
    parameter int  DEC_LAT = 1,
    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CODE_W-1:0] req_code,
    output logic [NREQ-1:0]        req_ready,
    output logic [CODE_W-1:0]      dec_in,
    input  logic [RES_W-1:0]       dec_res,
    output logic                   rsp_valid,
    output logic [IDX_W-1:0]       rsp_id,
    output logic [RES_W-1:0]       rsp_data,
    input  logic                   rsp_ready,
`ifdef DECODER_ARB_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic                   busy
);

    arb_state_e             state_q, state_d;
    logic [CODE_W-1:0]      dec_in_q, dec_in_d;
    logic [IDX_W-1:0]       rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]       rsp_data_q, rsp_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]        pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [NREQ-1:0]        gnt;

`ifdef DECODER_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   tmo_fire;
`endif

    decoder_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // Next-state and datapath updates for the grant/drive/wait/respond sequence.
    always_comb begin
        state_d     = state_q;
        dec_in_d    = dec_in_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt         = '0;
`ifdef DECODER_ARB_TIMEOUT_EN
        tmo_d       = '0;
        tmo_fire    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    gnt      = pick_gnt;
                    dec_in_d = req_code[int'(pick_idx)*CODE_W +: CODE_W];
                    rsp_id_d = pick_idx;
                    last_d   = pick_idx;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = LAT_CNT_W'(DEC_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = dec_res;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
`ifdef DECODER_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TMO_LIMIT)) begin
                    rsp_valid_d = 1'b0;
                    tmo_fire    = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves the pointer so index 0 is searched first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dec_in_q    <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            last_q      <= IDX_W'(NREQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dec_in_q    <= dec_in_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef DECODER_ARB_TIMEOUT_EN
    // Counts consecutive RESP cycles without acceptance; cleared outside RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_fire;
`endif

    // The grant is combinational from IDLE, so it is masked while reset is
    // asserted to keep req_ready low even if requests are already pending.
    assign req_ready = gnt & {NREQ{reset_n}};
    assign dec_in    = dec_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder_arb.sv
`timescale 1ns/1ps
// Bench for decoder_arb: a DEC_LAT=1 instance (table, contention, backpressure,
// withdrawn request, randomized run against a transaction model, optional
// timeout) and a DEC_LAT=4 instance (latency and reset-in-WAIT).
// Timing: inputs change 1ns after a rising edge, outputs sampled on the falling edge.
module tb_decoder_arb;
    localparam int NREQ   = 4;
    localparam int CODE_W = 7;
    localparam int RES_W  = 16;
    localparam int IDX_W  = 2;
    localparam int LAT_A  = 1;
    localparam int LAT_B  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NREQ-1:0]        a_valid, b_valid;
    logic [NREQ*CODE_W-1:0] a_code, b_code;
    logic [NREQ-1:0]        a_ready, b_ready;
    logic [CODE_W-1:0]      a_dec_in, b_dec_in;
    logic [RES_W-1:0]       a_dec_res, b_dec_res;
    logic                   a_rsp_valid, b_rsp_valid;
    logic [IDX_W-1:0]       a_rsp_id, b_rsp_id;
    logic [RES_W-1:0]       a_rsp_data, b_rsp_data;
    logic                   a_rsp_ready, b_rsp_ready;
    logic                   a_busy, b_busy;
`ifdef DECODER_ARB_TIMEOUT_EN
    logic                   a_tmo, b_tmo;
`endif

    decoder_arb #(.NREQ(NREQ), .CODE_W(CODE_W), .RES_W(RES_W), .DEC_LAT(LAT_A)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(a_valid), .req_code(a_code), .req_ready(a_ready),
        .dec_in(a_dec_in), .dec_res(a_dec_res),
        .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .rsp_ready(a_rsp_ready),
`ifdef DECODER_ARB_TIMEOUT_EN
        .timeout_err(a_tmo),
`endif
        .busy(a_busy)
    );

    decoder_arb #(.NREQ(NREQ), .CODE_W(CODE_W), .RES_W(RES_W), .DEC_LAT(LAT_B)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_valid), .req_code(b_code), .req_ready(b_ready),
        .dec_in(b_dec_in), .dec_res(b_dec_res),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
`ifdef DECODER_ARB_TIMEOUT_EN
        .timeout_err(b_tmo),
`endif
        .busy(b_busy)
    );

    // Decoder function: maps 7'b1100011 to 16'h00A5, other codes spread into the upper byte.
    function automatic logic [RES_W-1:0] dec_f(input logic [CODE_W-1:0] c);
        logic [15:0] w;
        w = {9'd0, c};
        return (w ^ 16'h00C6) + ((w - 16'd99) << 8);
    endfunction

    // Decoder models: result valid DEC_LAT cycles after dec_in changes.
    logic [CODE_W-1:0] a_pipe = '0;
    logic [CODE_W-1:0] b_pipe [LAT_B] = '{default: '0};
    always @(posedge clock) begin
        a_pipe <= a_dec_in;
        b_pipe[0] <= b_dec_in;
        for (int k = 1; k < LAT_B; k++) b_pipe[k] <= b_pipe[k-1];
    end
    assign a_dec_res = dec_f(a_pipe);
    assign b_dec_res = dec_f(b_pipe[LAT_B-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic logic [NREQ*CODE_W-1:0] codes_from(input logic [CODE_W-1:0] base);
        logic [NREQ*CODE_W-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*CODE_W +: CODE_W] = base + CODE_W'(i);
        return v;
    endfunction

    function automatic logic [CODE_W-1:0] code_of(input logic [NREQ*CODE_W-1:0] v, input int i);
        return v[i*CODE_W +: CODE_W];
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] oh);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (oh[k]) r = k;
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n     = 1'b0;
        a_valid     = '0; a_code = '0; a_rsp_ready = 1'b0;
        b_valid     = '0; b_code = '0; b_rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0]   mask;
        logic [CODE_W-1:0] base;
        int                exp_id;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   lat, ng, k;
        bit   got;
        int   ids[5];
        int   gcyc[5];
        logic [NREQ-1:0]   exp_ready;
        bit   exp_rv;
        bit   m_active;
        int   m_age, m_id, m_last, pick;
        logic [CODE_W-1:0] m_code;
        logic [RES_W-1:0]  m_data;

        // Round-robin pointer after reset is 3, so the search starts at 0.
        tbl[0] = '{4'b0100, 7'h61, 2};
        tbl[1] = '{4'b0101, 7'h10, 0};
        tbl[2] = '{4'b0101, 7'h20, 2};
        tbl[3] = '{4'b1000, 7'h30, 3};
        tbl[4] = '{4'b0011, 7'h40, 0};
        tbl[5] = '{4'b1111, 7'h50, 1};
        tbl[6] = '{4'b0001, 7'h70, 0};
        tbl[7] = '{4'b0010, 7'h7A, 1};

        a_valid = '0; a_code = '0; a_rsp_ready = 1'b0;
        b_valid = '0; b_code = '0; b_rsp_ready = 1'b0;

        // Reset values, with requests pending during reset.
        #1;
        reset_n = 1'b0;
        a_valid = '1;
        a_code  = codes_from(7'h01);
        smp();
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_dec_in", 32'(a_dec_in), 32'h0);
        chk("rst_rsp_id", 32'(a_rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(a_rsp_data), 32'h0);

        // Table-driven single transactions.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc();
            a_code      = codes_from(tbl[i].base);
            a_valid     = tbl[i].mask;
            a_rsp_ready = 1'b0;
            smp();
            chk("tbl_grant", 32'(a_ready), 32'(1) << tbl[i].exp_id);
            chk("tbl_busy_idle", 32'(a_busy), 32'h0);
            cyc();
            a_valid = '0;
            smp();
            chk("tbl_dec_in", 32'(a_dec_in), 32'(tbl[i].base + CODE_W'(tbl[i].exp_id)));
            chk("tbl_ready_low", 32'(a_ready), 32'h0);
            lat = 1;
            got = a_rsp_valid;
            while (!got && lat < 20) begin
                cyc();
                lat++;
                smp();
                got = a_rsp_valid;
            end
            // Grant in sample n, rsp_valid first seen in sample n+DEC_LAT+2
            // (DEC_LAT+1 edges after the transfer edge).
            chk("tbl_latency", 32'(lat), 32'(LAT_A + 2));
            chk("tbl_rsp_id", 32'(a_rsp_id), 32'(tbl[i].exp_id));
            chk("tbl_rsp_data", 32'(a_rsp_data), 32'(dec_f(tbl[i].base + CODE_W'(tbl[i].exp_id))));
            if (i == 0) chk("single_data", 32'(a_rsp_data), 32'h00A5);
            cyc();
            a_rsp_ready = 1'b1;
            smp();
            chk("tbl_hold", 32'(a_rsp_valid), 32'h1);
            cyc();
            a_rsp_ready = 1'b0;
            smp();
            chk("tbl_release", 32'(a_rsp_valid), 32'h0);
            chk("tbl_busy_after", 32'(a_busy), 32'h0);
        end

        // Contention: all requesters active, consumer always ready.
        do_reset();
        a_code      = codes_from(7'h05);
        a_valid     = '1;
        a_rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            smp();
            chk("cont_onehot", 32'($countones(a_ready) <= 1), 32'h1);
            if (a_ready != '0) begin
                ids[ng]  = idx_of(a_ready);
                gcyc[ng] = c;
                ng++;
            end
            cyc();
        end
        chk("cont_count", 32'(ng), 32'd5);
        for (int g = 0; g < ng; g++) chk("cont_order", 32'(ids[g]), 32'(g % NREQ));
        for (int g = 1; g < ng; g++) chk("cont_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'(LAT_A + 3));

        // Backpressure: response held for 10 cycles while others keep requesting.
        do_reset();
        a_code      = codes_from(7'h22);
        a_valid     = '1;
        a_rsp_ready = 1'b0;
        smp();
        chk("bp_grant", 32'(a_ready), 32'h1);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            cyc();
            a_code = 28'($urandom);
            lat++;
            smp();
            got = a_rsp_valid;
        end
        chk("bp_seen", 32'(got), 32'h1);
        for (int c = 0; c < 10; c++) begin
            cyc();
            a_code = 28'($urandom);
            smp();
            chk("bp_valid", 32'(a_rsp_valid), 32'h1);
            chk("bp_id", 32'(a_rsp_id), 32'h0);
            chk("bp_data", 32'(a_rsp_data), 32'(dec_f(7'h22)));
            chk("bp_no_grant", 32'(a_ready), 32'h0);
            chk("bp_busy", 32'(a_busy), 32'h1);
            chk("bp_dec_in", 32'(a_dec_in), 32'h22);
        end
        cyc();
        a_valid     = '0;
        a_rsp_ready = 1'b1;
        cyc();
        a_rsp_ready = 1'b0;
        smp();
        chk("bp_done_valid", 32'(a_rsp_valid), 32'h0);
        chk("bp_done_busy", 32'(a_busy), 32'h0);

        // Withdrawn request: requester 1 drops before its turn.
        do_reset();
        a_code      = codes_from(7'h33);
        a_valid     = 4'b1011;
        a_rsp_ready = 1'b1;
        ng = 0;
        ids[0] = -1;
        ids[1] = -1;
        for (int c = 0; c < 40; c++) begin
            smp();
            if (a_ready != '0 && ng < 5) begin
                ids[ng] = idx_of(a_ready);
                ng++;
            end
            cyc();
            if (ng == 1) a_valid = 4'b1001;
            if (ng >= 2) a_valid = '0;
        end
        chk("wd_count", 32'(ng), 32'd2);
        chk("wd_first", 32'(ids[0]), 32'd0);
        chk("wd_second", 32'(ids[1]), 32'd3);

        // DEC_LAT=4: full transaction latency, then reset in the 2nd WAIT cycle.
        do_reset();
        b_code  = codes_from(7'h48);
        b_valid = 4'b0010;
        smp();
        chk("b_grant1", 32'(b_ready), 32'h2);
        cyc();
        b_valid = '0;
        lat = 1;
        smp();
        got = b_rsp_valid;
        while (!got && lat < 20) begin
            cyc();
            lat++;
            smp();
            got = b_rsp_valid;
        end
        chk("b_latency", 32'(lat), 32'(LAT_B + 2));
        chk("b_rsp_id", 32'(b_rsp_id), 32'h1);
        chk("b_rsp_data", 32'(b_rsp_data), 32'(dec_f(7'h49)));
        cyc();
        b_rsp_ready = 1'b1;
        cyc();
        b_rsp_ready = 1'b0;
        b_code      = codes_from(7'h11);
        b_valid     = 4'b0100;
        smp();
        chk("b_grant2", 32'(b_ready), 32'h4);
        cyc();
        b_valid = '0;
        cyc();
        smp();
        chk("b_wait1_busy", 32'(b_busy), 32'h1);
        cyc();
        reset_n = 1'b0;
        b_valid = '1;
        smp();
        chk("b_rst_ready", 32'(b_ready), 32'h0);
        chk("b_rst_valid", 32'(b_rsp_valid), 32'h0);
        chk("b_rst_id", 32'(b_rsp_id), 32'h0);
        chk("b_rst_data", 32'(b_rsp_data), 32'h0);
        chk("b_rst_dec_in", 32'(b_dec_in), 32'h0);
        chk("b_rst_busy", 32'(b_busy), 32'h0);
        cyc();
        b_valid = '0;
        cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            smp();
            chk("b_post_valid", 32'(b_rsp_valid), 32'h0);
            chk("b_post_busy", 32'(b_busy), 32'h0);
            cyc();
        end

        // Randomized run against a transaction-level model.
        do_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_id     = 0;
        m_last   = NREQ - 1;
        m_code   = '0;
        m_data   = '0;
        for (int c = 0; c < 800; c++) begin
            cyc();
            a_valid     = 4'($urandom_range(0, 15));
            a_code      = 28'($urandom);
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            smp();
            exp_ready = '0;
            exp_rv    = 1'b0;
            pick      = -1;
            if (!m_active) begin
                for (int s = 1; s <= NREQ; s++) begin
                    k = (m_last + s) % NREQ;
                    if (pick < 0 && a_valid[k]) pick = k;
                end
                if (pick >= 0) exp_ready[pick] = 1'b1;
            end else begin
                m_age++;
                exp_rv = (m_age >= LAT_A + 2);
            end
            chk("rnd_ready", 32'(a_ready), 32'(exp_ready));
            chk("rnd_busy", 32'(a_busy), 32'(m_active));
            chk("rnd_rsp_valid", 32'(a_rsp_valid), 32'(exp_rv));
            chk("rnd_dec_in", 32'(a_dec_in), 32'(m_code));
            if (exp_rv) begin
                chk("rnd_rsp_id", 32'(a_rsp_id), 32'(m_id));
                chk("rnd_rsp_data", 32'(a_rsp_data), 32'(m_data));
            end
            if (!m_active && pick >= 0) begin
                m_active = 1'b1;
                m_age    = 0;
                m_id     = pick;
                m_code   = code_of(a_code, pick);
                m_data   = dec_f(m_code);
                m_last   = pick;
            end else if (m_active && exp_rv && a_rsp_ready) begin
                m_active = 1'b0;
            end
        end

`ifdef DECODER_ARB_TIMEOUT_EN
        // Timeout: consumer never accepts; error pulses in the 256th RESP cycle.
        do_reset();
        a_code      = codes_from(7'h2A);
        a_valid     = 4'b0001;
        a_rsp_ready = 1'b0;
        smp();
        chk("tmo_grant", 32'(a_ready), 32'h1);
        cyc();
        a_valid = '0;
        lat = 1;
        smp();
        got = a_rsp_valid;
        while (!got && lat < 20) begin
            cyc();
            lat++;
            smp();
            got = a_rsp_valid;
        end
        chk("tmo_resp_seen", 32'(got), 32'h1);
        k   = 1;
        pick = 0;
        while (pick == 0 && k < 300) begin
            if (a_tmo) begin
                pick = k;
            end else begin
                cyc();
                k++;
                smp();
            end
        end
        chk("tmo_cycle", 32'(pick), 32'd256);
        cyc();
        a_valid = 4'b0010;
        smp();
        chk("tmo_pulse_width", 32'(a_tmo), 32'h0);
        chk("tmo_dropped", 32'(a_rsp_valid), 32'h0);
        chk("tmo_idle", 32'(a_busy), 32'h0);
        chk("tmo_next_grant", 32'(a_ready), 32'h2);
        cyc();
        a_valid = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_arb.md
DECODER_ARB -- requirements
Module: decoder_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the decoder (2..8).
REQ-002 Parameter CODE_W, default 7, width of a decoder input code.
REQ-003 Parameter RES_W, default 16, width of the decoder result.
REQ-004 Parameter DEC_LAT, default 1, cycles from dec_in change to valid dec_res (1..7).
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NREQ  per-requester request strobe.
REQ-008 req_code  input  NREQ*CODE_W  per-requester code; slice i belongs to requester i.
REQ-009 req_ready  output  NREQ  one-hot grant/accept, at most one bit high per cycle.
REQ-010 dec_in  output  CODE_W  registered code driven into the shared decoder.
REQ-011 dec_res  input  RES_W  decoder result.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that owns the response.
REQ-014 rsp_data  output  RES_W  captured decoder result.
REQ-015 rsp_ready  input  1  response consumer accept.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, DRIVE, WAIT, RESP; encoding is free but taken from the package.
REQ-018 IDLE: if any req_valid is high, the arbiter selects one requester, pulses its req_ready for one cycle, latches its code into dec_in and its index into rsp_id, then goes to DRIVE.
REQ-019 Handshake: a request transfers only on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-020 req_ready is never high outside IDLE.
REQ-021 Arbitration is round-robin: search starts at the index after the last grant, wrapping from NREQ-1 to 0. After reset the search starts at index 0.
REQ-022 DRIVE lasts one cycle, then goes to WAIT with a counter loaded to DEC_LAT-1.
REQ-023 WAIT decrements the counter each cycle. When the counter is 0, dec_res is captured into rsp_data, rsp_valid is set, and the FSM goes to RESP.
REQ-024 Minimum grant-to-rsp_valid latency is DEC_LAT+1 cycles.
REQ-025 RESP holds rsp_valid, rsp_id and rsp_data stable until rsp_ready is high.
REQ-026 On the accepting cycle, rsp_valid clears and the FSM returns to IDLE. No new grant is issued in that same cycle, so grants are spaced at least DEC_LAT+3 cycles apart.
REQ-027 dec_in holds its value from grant until the next grant; it does not change in RESP.
REQ-028 A requester that drops req_valid before being granted is skipped without error.
REQ-029 rsp_ready high while rsp_valid is low is ignored.

Reset
REQ-030 When reset_n is low: FSM=IDLE, dec_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0, round-robin pointer=last-grant index NREQ-1.
REQ-031 Reset mid-transaction discards the pending response. No rsp_valid is produced for it after reset is released.

Configuration
REQ-032 Macro DECODER_ARB_TIMEOUT_EN, when defined, adds an 8-bit counter in RESP.
REQ-033 With DECODER_ARB_TIMEOUT_EN defined: if rsp_ready stays low for 255 consecutive RESP cycles, the response is dropped, output timeout_err pulses high for 1 cycle, and the FSM returns to IDLE.
REQ-034 Without DECODER_ARB_TIMEOUT_EN: the timeout_err port and the counter do not exist, and RESP waits indefinitely.

Structure
REQ-035 Package decoder_arb_pkg holds the FSM state typedef, the default widths (CODE_W=7, RES_W=16) and the timeout limit constant (255).
REQ-036 Round-robin selection lives in sub-module decoder_rr_pick: combinational inputs are the request vector and the last-grant index; outputs are a one-hot grant and an index.

Verification
REQ-037 Single request: req_valid[2]=1, code 7'b1100011, DEC_LAT=1, decoder model returns 16'h00A5 -> req_ready[2] pulses once; rsp_valid rises 2 cycles later with rsp_id=2 and rsp_data=16'h00A5.
REQ-038 Contention: all 4 req_valid held high, rsp_ready tied to 1 -> grant order after reset is 0,1,2,3,0; no two req_ready bits are ever high together.
REQ-039 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid, rsp_id and rsp_data stay constant, there is no new grant, and busy=1 throughout.
REQ-040 Reset mid-WAIT with DEC_LAT=4: assert reset_n=0 in the 2nd WAIT cycle -> all outputs take their reset values immediately, and no rsp_valid appears after release.
REQ-041 Withdrawn request: req_valid[1] pulses low before its turn while requesters 0 and 3 are active -> grant sequence is 0,3.
REQ-042 With DECODER_ARB_TIMEOUT_EN defined and rsp_ready held low -> timeout_err pulses in the 256th RESP cycle, the FSM returns to IDLE, and the next request is granted normally.
